// File: rtl/mic_pkg.sv
// Shared constants and types for the LOA microphone front end.
// Sample midpoint, level width, amplitude-to-level shift and alarm FSM states.
package mic_pkg;

    localparam logic [11:0] MIC_MID = 12'd2048;
    localparam int LEVEL_W = 4;
    localparam int AMP_SHIFT = 7;

    typedef enum logic [1:0] {
        QUIET,
        ARMING,
        LOUD,
        RELEASING
    } loa_state_t;

endpackage

// File: rtl/loa_detect_if.sv
// Sample stream in, volume level and loud-alarm flag out.
// The master side feeds samples; the detector is the slave side.
interface loa_detect_if;
    import mic_pkg::*;

    logic               sample_valid;
    logic [11:0]        mic_in;
    logic [LEVEL_W-1:0] level;
    logic               level_valid;
    logic               LOA;

    modport master (
        output sample_valid,
        output mic_in,
        input  level,
        input  level_valid,
        input  LOA
    );

    modport slave (
        input  sample_valid,
        input  mic_in,
        output level,
        output level_valid,
        output LOA
    );

endinterface

// File: rtl/loa_detect_peak_window.sv
// Peak amplitude over fixed windows of valid samples.
// Exposes the window-closing strobe and its level combinationally for the FSM.
module peak_window
    import mic_pkg::*;
#(
    parameter int WINDOW = 2000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic [11:0]        mic_in,
    output logic               win_end,
    output logic [LEVEL_W-1:0] new_level,
    output logic [LEVEL_W-1:0] level,
    output logic               level_valid
);

    localparam int CNT_W = $clog2(WINDOW);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

    logic [10:0]      amp;
    logic [10:0]      pk_max;
    logic [10:0]      peak;
    logic [CNT_W-1:0] cnt;

    // Samples below midpoint only contribute zero amplitude
    always_comb begin
        amp = '0;
        if (mic_in >= MIC_MID) begin
            amp = 11'(mic_in - MIC_MID);
        end
        pk_max = (amp > peak) ? amp : peak;
        new_level = LEVEL_W'(pk_max >> AMP_SHIFT);
        win_end = sample_valid && (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak        <= '0;
            cnt         <= '0;
            level       <= '0;
            level_valid <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            if (win_end) begin
                level       <= new_level;
                level_valid <= 1'b1;
                peak        <= '0;
                cnt         <= '0;
            end else if (sample_valid) begin
                peak <= pk_max;
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/loa_detect.sv
// Loud-alarm detector: windowed peak level plus a debounced hysteresis FSM.
// LOA is registered and follows the level of the window closing that cycle.
module loa_detect
    import mic_pkg::*;
#(
    parameter int WINDOW      = 2000,
    parameter int THRESH      = 12,
    parameter int ASSERT_WIN  = 3,
    parameter int RELEASE_WIN = 10
) (
    input  logic  CLOCK,
    input  logic  RESET,
    loa_detect_if.slave bus
);

    logic               win_end;
    logic [LEVEL_W-1:0] new_level;
    logic [LEVEL_W-1:0] level_q;
    logic               level_valid_q;
    logic               loud;
    loa_state_t         state;
    loa_state_t         state_n;
    logic [3:0]         run;
    logic [3:0]         run_n;
    logic               loa_q;

    peak_window #(
        .WINDOW(WINDOW)
    ) u_peak (
        .clk         (CLOCK),
        .rst         (RESET),
        .sample_valid(bus.sample_valid),
        .mic_in      (bus.mic_in),
        .win_end     (win_end),
        .new_level   (new_level),
        .level       (level_q),
        .level_valid (level_valid_q)
    );

    assign loud = (new_level >= LEVEL_W'(THRESH));

    always_comb begin
        state_n = state;
        run_n   = run;
        if (win_end) begin
            unique case (state)
                QUIET: begin
                    if (loud) begin
                        if (ASSERT_WIN == 1) begin
                            state_n = LOUD;
                            run_n   = '0;
                        end else begin
                            state_n = ARMING;
                            run_n   = 4'd1;
                        end
                    end
                end
                ARMING: begin
                    if (!loud) begin
                        state_n = QUIET;
                        run_n   = '0;
                    end else if (run + 4'd1 == 4'(ASSERT_WIN)) begin
                        state_n = LOUD;
                        run_n   = '0;
                    end else begin
                        run_n = run + 4'd1;
                    end
                end
                LOUD: begin
                    if (!loud) begin
                        if (RELEASE_WIN == 1) begin
                            state_n = QUIET;
                            run_n   = '0;
                        end else begin
                            state_n = RELEASING;
                            run_n   = 4'd1;
                        end
                    end
                end
                RELEASING: begin
                    if (loud) begin
                        state_n = LOUD;
                        run_n   = '0;
                    end else if (run + 4'd1 == 4'(RELEASE_WIN)) begin
                        state_n = QUIET;
                        run_n   = '0;
                    end else begin
                        run_n = run + 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= QUIET;
            run   <= '0;
            loa_q <= 1'b0;
        end else begin
            state <= state_n;
            run   <= run_n;
            loa_q <= (state_n == LOUD) || (state_n == RELEASING);
        end
    end

    assign bus.level       = level_q;
    assign bus.level_valid = level_valid_q;
    assign bus.LOA         = loa_q;

endmodule

// File: tb/tb_loa_detect.sv
// Directed bench for loa_detect: reset, peak/level, boundaries, alarm hysteresis.
// Uses WINDOW=8, THRESH=12, ASSERT_WIN=3, RELEASE_WIN=2.
module tb_loa_detect;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   pulses;
    logic lv_last;
    logic loa_pre;
    logic [11:0] vec [8];

    loa_detect_if bus ();

    loa_detect #(
        .WINDOW     (8),
        .THRESH     (12),
        .ASSERT_WIN (3),
        .RELEASE_WIN(2)
    ) dut (
        .CLOCK(clk),
        .RESET(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [11:0] v);
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.mic_in = v;
        @(posedge clk);
        #1;
        if (bus.level_valid) pulses++;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.sample_valid = 1'b0;
        @(posedge clk);
        #1;
        if (bus.level_valid) pulses++;
    endtask

    task automatic run_win(input int gap);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) loa_pre = bus.LOA;
            send(vec[i]);
            if (i < 7) begin
                for (int g = 0; g < gap; g++) idle();
            end
        end
        lv_last = bus.level_valid;
    endtask

    task automatic fill(input logic [11:0] base, input logic [11:0] hit);
        for (int i = 0; i < 8; i++) vec[i] = base;
        vec[3] = hit;
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        pulses = 0;
        rst = 1'b1;
        bus.sample_valid = 1'b1;
        bus.mic_in = 12'd4095;
        repeat (2) @(posedge clk);
        #1;
        check("reset_level", int'(bus.level), 0);
        check("reset_level_valid", int'(bus.level_valid), 0);
        check("reset_loa", int'(bus.LOA), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.sample_valid = 1'b0;

        vec = '{12'd2048, 12'd2300, 12'd4095, 12'd2048,
                12'd100, 12'd2048, 12'd2048, 12'd2048};
        run_win(0);
        check("w1_pulses", pulses, 1);
        check("w1_lv_timing", int'(lv_last), 1);
        check("w1_level", int'(bus.level), 15);
        check("w1_loa", int'(bus.LOA), 0);
        idle();
        check("w1_lv_one_cycle", int'(bus.level_valid), 0);

        fill(12'd2175, 12'd2175);
        run_win(0);
        check("b2175_level", int'(bus.level), 0);
        check("b2175_lv", int'(lv_last), 1);
        fill(12'd2176, 12'd2176);
        run_win(0);
        check("b2176_level", int'(bus.level), 1);

        fill(12'd2048, 12'd3800);
        run_win(0);
        check("assert_w1_loa", int'(bus.LOA), 0);
        run_win(0);
        check("assert_w2_loa", int'(bus.LOA), 0);
        run_win(0);
        check("assert_w3_pre_loa", int'(loa_pre), 0);
        check("assert_w3_loa", int'(bus.LOA), 1);
        check("assert_w3_level", int'(bus.level), 13);

        fill(12'd2048, 12'd2048);
        run_win(0);
        check("hyst_quiet1_loa", int'(bus.LOA), 1);
        fill(12'd2048, 12'd3800);
        run_win(0);
        check("hyst_loud_loa", int'(bus.LOA), 1);
        fill(12'd2048, 12'd2048);
        run_win(0);
        check("hyst_quiet_a_loa", int'(bus.LOA), 1);
        run_win(0);
        check("hyst_quiet_b_pre", int'(loa_pre), 1);
        check("hyst_quiet_b_loa", int'(bus.LOA), 0);

        idle();
        fill(12'd2048, 12'd2600);
        run_win(4);
        check("gap_pulses", pulses, 1);
        check("gap_lv_timing", int'(lv_last), 1);
        check("gap_level", int'(bus.level), 4);

        for (int i = 0; i < 4; i++) send(12'd4095);
        @(negedge clk);
        rst = 1'b1;
        bus.mic_in = 12'd4095;
        @(posedge clk);
        #1;
        check("midreset_level", int'(bus.level), 0);
        check("midreset_lv", int'(bus.level_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        bus.sample_valid = 1'b0;
        fill(12'd2048, 12'd2400);
        run_win(0);
        check("fresh_pulses", pulses, 1);
        check("fresh_lv_timing", int'(lv_last), 1);
        check("fresh_level", int'(bus.level), 2);
        check("fresh_loa", int'(bus.LOA), 0);

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/loa_detect.md
# loa_detect

- Upstream stage of the "LOA" seven-segment display driver.
- Consumes the 12-bit microphone sample stream and measures peak amplitude over fixed windows, producing a 4-bit volume level.
- Drives the display driver's `LOA` enable input through a debounced loud-alarm state machine with separate assert and release hysteresis.

## Interface
- `WINDOW`, default 2000: valid samples per measurement window (0.1 s at 20 kHz); legal range 2..65535.
- `THRESH`, default 12: level (0..15) at or above which a window counts as loud.
- `ASSERT_WIN`, default 3: consecutive loud windows required to raise `LOA`; legal range 1..15.
- `RELEASE_WIN`, default 10: consecutive quiet windows required to drop `LOA`; legal range 1..15.
- `CLOCK` input 1: system clock. One clock domain only.
- `RESET` input 1: synchronous, active-high reset.
- `sample_valid` input 1: one-cycle strobe; `mic_in` is valid in that cycle.
- `mic_in` input 12: unsigned mic sample, midpoint 2048.
- `level` output 4: volume level of the last completed window.
- `level_valid` output 1: one-cycle pulse when `level` updates.
- `LOA` output 1: loud-alarm flag, level-sensitive; goes to the display driver.

## Operation
- **Amplitude:**
  - `amp = mic_in - 2048` when `mic_in >= 2048`, else 0.
  - Result is 11 bits, range 0..2047.
- **Peak tracking:**
  - On each `sample_valid`, `peak <= max(peak, amp)`.
  - `sample_cnt` counts valid samples, 0..WINDOW-1.
- **Window end:**
  - Triggered by a valid sample with `sample_cnt == WINDOW-1`.
  - That sample is included in the window.
  - `level <= max(peak, amp) >> 7` (0..15, no saturation needed).
  - `peak <= 0`.
  - `sample_cnt <= 0`.
  - `level_valid` pulses.
- **Loud test:** a window is loud iff its new level is >= `THRESH`.
- **FSM**, evaluated only on window-end cycles:
  - QUIET (LOA=0):
    - loud → ARMING with `run = 1`, or LOUD directly if `ASSERT_WIN == 1`.
  - ARMING (LOA=0):
    - loud → `run++`; when `run` reaches `ASSERT_WIN`, go to LOUD.
    - quiet → QUIET, `run = 0`.
  - LOUD (LOA=1):
    - quiet → RELEASING with `run = 1`, or QUIET directly if `RELEASE_WIN == 1`.
    - loud → stay in LOUD.
  - RELEASING (LOA=1):
    - quiet → `run++`; when `run` reaches `RELEASE_WIN`, go to QUIET.
    - loud → LOUD, `run = 0`.
- **Output decode:** `LOA` is registered, 1 in LOUD and RELEASING, 0 otherwise.
- **Gaps in valid:** cycles without `sample_valid` change nothing. There is no timeout, and the window length is in samples, not cycles.

## Timing
- **Reset values:**
  - `level = 0`, `level_valid = 0`, `LOA = 0`.
  - FSM = QUIET, `peak = 0`, `sample_cnt = 0`, `run = 0`.
  - `RESET` overrides a coincident `sample_valid`; that sample is discarded.
  - Reset mid-window discards the partial window.
- **Latency:**
  - `level` and `level_valid` appear on the cycle after the window-closing sample's strobe.
  - `LOA` changes on that same cycle, computed from the new level. The FSM uses the next-state level, not the stale register.
  - With `ASSERT_WIN = 3`, `LOA` rises 1 cycle after the 3rd consecutive loud window closes.
- **Back-to-back samples:** `sample_valid` may be high every cycle; full throughput is required.
- **Boundary values:**
  - `mic_in = 4095` → amp 2047 → level 15.
  - `mic_in <= 2175` → level 0.
  - `mic_in = 2176` → level 1.
- **Counter wrap:** `sample_cnt` wraps only via the window-end rule and never exceeds WINDOW-1. `run` never exceeds `max(ASSERT_WIN, RELEASE_WIN)`.

## Structure
- **Shared package `mic_pkg`:**
  - `MIC_MID = 12'd2048`.
  - `LEVEL_W = 4`.
  - `AMP_SHIFT = 7`.
  - FSM state enum `loa_state_t` {QUIET, ARMING, LOUD, RELEASING}.
- **Sub-module `peak_window`:**
  - Contains the amplitude, peak and `sample_cnt` logic.
  - Outputs `level` and `level_valid`.
  - The top level holds only the hysteresis FSM and the `LOA` register.

## Test plan
Parameters for all scenarios: `WINDOW = 8`, `THRESH = 12`, `ASSERT_WIN = 3`, `RELEASE_WIN = 2`.
- **Reset:** assert `RESET` 2 cycles with `sample_valid` high → `level = 0`, `level_valid = 0`, `LOA = 0`; no window completes.
- **Peak/level:** 8 samples [2048, 2300, 4095, 2048, 100, 2048, 2048, 2048] → `level = 15` with one `level_valid` pulse.
- **Boundary:** next window all 2175 → `level = 0`; following window all 2176 → `level = 1`.
- **Assert:** 3 consecutive windows containing a 3800 sample (level 13) → `LOA` rises exactly 1 cycle after the 3rd window's last strobe, not after the 2nd.
- **Hysteresis:**
  - In LOUD, one quiet window then one loud window → `LOA` stays 1.
  - Then two quiet windows → `LOA` falls 1 cycle after the second.
- **Gapped valid:** `sample_valid` every 5th cycle, 8 samples → `level_valid` 1 cycle after the 8th strobe. Then `RESET` asserted after 4 samples of the next window → a following window of 8 fresh samples reports only those samples.
